// File: rtl/wb_timer_mc.sv
// Multi-channel Wishbone compare timer: one shared prescaler tick advances NCH
// independent count/compare channels with sticky match flags and per-channel irq.
module wb_timer_mc #(
  parameter int NCH   = 2,
  parameter int CNT_W = 32,
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_cyc,
  input  logic             wb_stb,
  input  logic             wb_we,
  input  logic [31:0]      wb_adr,
  input  logic [3:0]       wb_sel,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack,
  output logic             wb_stall,
  output logic [NCH-1:0]   irq,
  output logic             irq_any
);

  localparam logic [5:0] ADR_PRESCALE = 6'h20;
  localparam logic [5:0] ADR_PENDING  = 6'h21;

  logic             req;
  logic             wr;
  logic [5:0]       word;
  logic [2:0]       ch_sel;
  logic [1:0]       reg_sel;
  logic             unused_adr;

  logic [CNT_W-1:0] count_q     [NCH];
  logic [CNT_W-1:0] cmp_q       [NCH];
  logic [CNT_W-1:0] count_wdata [NCH];
  logic [CNT_W-1:0] cmp_wdata   [NCH];
  logic [NCH-1:0]   en_q;
  logic [NCH-1:0]   ar_q;
  logic [NCH-1:0]   ien_q;
  logic [NCH-1:0]   match_q;
  logic [NCH-1:0]   wr_ctrl;
  logic [NCH-1:0]   wr_count;
  logic [NCH-1:0]   wr_cmp;
  logic [NCH-1:0]   wr_stat;
  logic [NCH-1:0]   act;
  logic [NCH-1:0]   hit;

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_cnt_q;
  logic [PRE_W-1:0] pre_wdata;
  logic             wr_pre;
  logic             tick;

  logic [31:0]      rd_data;

  assign req        = wb_cyc & wb_stb;
  assign wr         = req & wb_we;
  assign word       = wb_adr[7:2];
  assign ch_sel     = word[4:2];
  assign reg_sel    = word[1:0];
  assign unused_adr = ^{wb_adr[31:8], wb_adr[1:0]};
  assign wb_stall   = 1'b0;

  assign wr_pre = wr & (word == ADR_PRESCALE);
  assign tick   = (pre_cnt_q == pre_q);

  always_comb begin
    wr_ctrl  = '0;
    wr_count = '0;
    wr_cmp   = '0;
    wr_stat  = '0;
    for (int c = 0; c < NCH; c++) begin
      if (wr && !word[5] && (ch_sel == 3'(c))) begin
        case (reg_sel)
          2'd0:    wr_ctrl[c]  = 1'b1;
          2'd1:    wr_count[c] = 1'b1;
          2'd2:    wr_cmp[c]   = 1'b1;
          default: wr_stat[c]  = 1'b1;
        endcase
      end
    end
  end

  // A software COUNT write, or a CTRL write that drops EN, pre-empts this cycle's tick.
  always_comb begin
    act = '0;
    hit = '0;
    for (int c = 0; c < NCH; c++) begin
      count_wdata[c] = count_q[c];
      cmp_wdata[c]   = cmp_q[c];
      for (int i = 0; i < CNT_W; i++) begin
        if (wb_sel[i/8]) begin
          count_wdata[c][i] = wb_dat_i[i];
          cmp_wdata[c][i]   = wb_dat_i[i];
        end
      end
      act[c] = tick & en_q[c] & ~wr_count[c] & ~(wr_ctrl[c] & wb_sel[0] & ~wb_dat_i[0]);
      hit[c] = act[c] & (count_q[c] == cmp_q[c]);
    end
  end

  always_comb begin
    pre_wdata = pre_q;
    for (int i = 0; i < PRE_W; i++) begin
      if (wb_sel[i/8]) begin
        pre_wdata[i] = wb_dat_i[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q     <= '0;
      pre_cnt_q <= '0;
    end else begin
      if (wr_pre) begin
        pre_q     <= pre_wdata;
        pre_cnt_q <= '0;
      end else if (tick) begin
        pre_cnt_q <= '0;
      end else begin
        pre_cnt_q <= pre_cnt_q + PRE_W'(1);
      end
    end
  end

  // Software CTRL writes are applied after the tick effects so they win over a one-shot EN clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q    <= '0;
      ar_q    <= '0;
      ien_q   <= '0;
      match_q <= '0;
      for (int c = 0; c < NCH; c++) begin
        count_q[c] <= '0;
        cmp_q[c]   <= '1;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (act[c]) begin
          if (hit[c]) begin
            if (ar_q[c]) begin
              count_q[c] <= '0;
            end else begin
              en_q[c] <= 1'b0;
            end
          end else begin
            count_q[c] <= count_q[c] + CNT_W'(1);
          end
        end
        if (wr_count[c]) begin
          count_q[c] <= count_wdata[c];
        end
        if (wr_cmp[c]) begin
          cmp_q[c] <= cmp_wdata[c];
        end
        if (wr_ctrl[c] && wb_sel[0]) begin
          en_q[c]  <= wb_dat_i[0];
          ar_q[c]  <= wb_dat_i[1];
          ien_q[c] <= wb_dat_i[2];
        end
        match_q[c] <= (match_q[c] & ~(wr_stat[c] & wb_sel[0] & wb_dat_i[0])) | hit[c];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (word == ADR_PRESCALE) begin
      rd_data[PRE_W-1:0] = pre_q;
    end else if (word == ADR_PENDING) begin
      rd_data[NCH-1:0] = match_q;
    end else if (!word[5]) begin
      for (int c = 0; c < NCH; c++) begin
        if (ch_sel == 3'(c)) begin
          case (reg_sel)
            2'd0:    rd_data[2:0]       = {ien_q[c], ar_q[c], en_q[c]};
            2'd1:    rd_data[CNT_W-1:0] = count_q[c];
            2'd2:    rd_data[CNT_W-1:0] = cmp_q[c];
            default: rd_data[0]         = match_q[c];
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_ack   <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack   <= req;
      wb_dat_o <= (req && !wb_we) ? rd_data : '0;
    end
  end

  assign irq     = match_q & ien_q;
  assign irq_any = |irq;

endmodule

// File: tb/tb_wb_timer_mc.sv
// Scoreboard bench for wb_timer_mc: driver steps a behavioural model and queues
// expected bus responses; a monitor compares acks, read data and irq every cycle.
module tb_wb_timer_mc;
  localparam int NCH = 3;
  localparam int CNT_W = 32;
  localparam int PRE_W = 16;
  localparam longint CNT_MOD = 64'd1 << CNT_W;
  localparam longint PRE_MOD = 64'd1 << PRE_W;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           wb_cyc = 1'b0;
  logic           wb_stb = 1'b0;
  logic           wb_we = 1'b0;
  logic [31:0]    wb_adr = '0;
  logic [3:0]     wb_sel = '0;
  logic [31:0]    wb_dat_i = '0;
  logic [31:0]    wb_dat_o;
  logic           wb_ack;
  logic           wb_stall;
  logic [NCH-1:0] irq;
  logic           irq_any;

  always #5 clk = ~clk;

  wb_timer_mc #(.NCH(NCH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .clk(clk), .rst(rst), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_adr(wb_adr), .wb_sel(wb_sel), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack(wb_ack), .wb_stall(wb_stall), .irq(irq), .irq_any(irq_any)
  );

  typedef struct {
    bit          is_read;
    logic [31:0] adr;
    logic [31:0] data;
    int          exp_cyc;
  } exp_t;

  exp_t sb[$];
  int   cycle_no = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cycle_no <= cycle_no + 1;

  // Reference model: timer state as plain integers, advanced once per clock edge
  longint m_cnt[NCH];
  longint m_cmp[NCH];
  bit     m_en[NCH];
  bit     m_ar[NCH];
  bit     m_ien[NCH];
  bit     m_match[NCH];
  longint m_pre;
  longint m_pcnt;

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = 0; m_cmp[c] = CNT_MOD - 1;
      m_en[c] = 0; m_ar[c] = 0; m_ien[c] = 0; m_match[c] = 0;
    end
    m_pre = 0;
    m_pcnt = 0;
  endfunction

  function automatic longint merge_bytes(longint old_v, logic [31:0] dat, logic [3:0] sel, longint modv);
    longint r;
    longint b_new;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) begin
        b_new = longint'((dat >> (8 * b)) & 32'hFF);
        r = r - (((r >> (8 * b)) & 255) << (8 * b)) + (b_new << (8 * b));
      end
    end
    return r % modv;
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] adr);
    int          w;
    int          ch;
    logic [31:0] p;
    w = int'(adr[7:2]);
    ch = w / 4;
    p = '0;
    if (w == 32) return 32'(m_pre);
    if (w == 33) begin
      for (int c = 0; c < NCH; c++) p[c] = m_match[c];
      return p;
    end
    if (w < 32 && ch < NCH) begin
      case (w % 4)
        0: p = {29'd0, m_ien[ch], m_ar[ch], m_en[ch]};
        1: p = 32'(m_cnt[ch]);
        2: p = 32'(m_cmp[ch]);
        default: p = {31'd0, m_match[ch]};
      endcase
    end
    return p;
  endfunction

  function automatic void model_step(bit r, bit cy, bit st, bit we, logic [31:0] adr, logic [3:0] sel, logic [31:0] dat);
    bit tick;
    bit wr;
    bit chan_wr;
    int w;
    int ch;
    int rg;
    bit fire[NCH];
    if (r) begin
      model_reset();
      return;
    end
    wr = cy && st && we;
    w = int'(adr[7:2]);
    ch = w / 4;
    rg = w % 4;
    chan_wr = wr && (w < 32) && (ch < NCH);
    tick = (m_pcnt == m_pre);
    for (int c = 0; c < NCH; c++) begin
      fire[c] = 0;
      if (tick && m_en[c]
          && !(chan_wr && ch == c && rg == 1)
          && !(chan_wr && ch == c && rg == 0 && sel[0] && !dat[0])) begin
        if (m_cnt[c] == m_cmp[c]) begin
          fire[c] = 1;
          if (m_ar[c]) m_cnt[c] = 0;
          else m_en[c] = 0;
        end else begin
          m_cnt[c] = (m_cnt[c] + 1) % CNT_MOD;
        end
      end
    end
    if (wr && w == 32) begin
      m_pre = merge_bytes(m_pre, dat, sel, PRE_MOD);
      m_pcnt = 0;
    end else if (tick) begin
      m_pcnt = 0;
    end else begin
      m_pcnt = m_pcnt + 1;
    end
    if (chan_wr) begin
      case (rg)
        0: if (sel[0]) begin m_en[ch] = dat[0]; m_ar[ch] = dat[1]; m_ien[ch] = dat[2]; end
        1: m_cnt[ch] = merge_bytes(m_cnt[ch], dat, sel, CNT_MOD);
        2: m_cmp[ch] = merge_bytes(m_cmp[ch], dat, sel, CNT_MOD);
        default: if (sel[0] && dat[0]) m_match[ch] = 0;
      endcase
    end
    for (int c = 0; c < NCH; c++) if (fire[c]) m_match[c] = 1;
  endfunction

  function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle_no);
  endfunction

  task automatic applyStimulus(bit r, bit cy, bit st, bit we, logic [31:0] adr, logic [3:0] sel, logic [31:0] dat);
    exp_t e;
    @(negedge clk);
    rst = r; wb_cyc = cy; wb_stb = st; wb_we = we;
    wb_adr = adr; wb_sel = sel; wb_dat_i = dat;
    if (r) begin
      sb.delete();
    end else if (cy && st) begin
      e.is_read = !we;
      e.adr = adr;
      e.data = we ? 32'd0 : model_read(adr);
      e.exp_cyc = cycle_no + 1;
      sb.push_back(e);
    end
    model_step(r, cy, st, we, adr, sel, dat);
  endtask

  task automatic busWrite(logic [31:0] adr, logic [31:0] dat, logic [3:0] sel = 4'hF);
    applyStimulus(0, 1, 1, 1, adr, sel, dat);
  endtask

  task automatic busRead(logic [31:0] adr);
    applyStimulus(0, 1, 1, 0, adr, 4'hF, 32'd0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 32'd0, 4'h0, 32'd0);
  endtask

  // Monitor: samples 1 time unit after each rising edge
  initial begin
    exp_t           e;
    bit             exp_ack;
    logic [NCH-1:0] exp_irq;
    model_reset();
    forever begin
      @(posedge clk);
      #1;
      exp_ack = (sb.size() > 0) && (sb[0].exp_cyc == cycle_no);
      checkOutput("ack", 32'(wb_ack), 32'(exp_ack));
      if (exp_ack) begin
        e = sb.pop_front();
        if (e.is_read && wb_ack) checkOutput($sformatf("rdata@%h", e.adr), wb_dat_o, e.data);
      end
      exp_irq = '0;
      for (int c = 0; c < NCH; c++) exp_irq[c] = m_match[c] & m_ien[c];
      checkOutput("irq", 32'(irq), 32'(exp_irq));
      checkOutput("irq_any", 32'(irq_any), 32'(|exp_irq));
      checkOutput("stall", 32'(wb_stall), 32'd0);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          word;
    int          ch;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    bit          we;

    applyStimulus(1, 0, 0, 0, 32'd0, 4'h0, 32'd0);
    applyStimulus(1, 0, 0, 0, 32'd0, 4'h0, 32'd0);
    for (int i = 0; i < 16; i++) busRead(32'(i * 4));
    busRead(32'h80); busRead(32'h84); busRead(32'h90);

    // Auto-reload channel 0 with irq, counting every cycle
    busWrite(32'h80, 32'd0);
    busWrite(32'h08, 32'd3);
    busWrite(32'h00, 32'h7);
    for (int i = 0; i < 12; i++) busRead(32'h04);
    busRead(32'h0C); busRead(32'h84);

    // W1C every cycle so it collides with a new match on some cycle
    for (int i = 0; i < 8; i++) busWrite(32'h0C, 32'h1);
    busWrite(32'h00, 32'h4);
    idle(2);
    busWrite(32'h0C, 32'h0);
    busRead(32'h0C);
    busWrite(32'h0C, 32'h1);
    idle(2);
    busRead(32'h0C);

    // One-shot channel 1 with prescale 4
    busWrite(32'h80, 32'd4);
    busWrite(32'h18, 32'd2);
    busWrite(32'h10, 32'h1);
    for (int i = 0; i < 24; i++) busRead((i % 2 == 0) ? 32'h14 : 32'h10);
    busRead(32'h1C); busRead(32'h84);

    // All-ones wrap on channel 2
    busWrite(32'h80, 32'hFFFF0000);
    busWrite(32'h28, 32'h10);
    busWrite(32'h24, 32'hFFFFFFFF);
    busWrite(32'h20, 32'h1);
    for (int i = 0; i < 4; i++) busRead(32'h24);
    busRead(32'h2C);

    // Byte-lane write, unmapped reads and ignored writes
    busWrite(32'h20, 32'h0);
    busWrite(32'h24, 32'h12345678);
    busWrite(32'h24, 32'hAABBCC55, 4'b0001);
    busRead(32'h24);
    busRead(32'h90);
    busWrite(32'h84, 32'hFFFFFFFF);
    busWrite(32'h30, 32'hFFFFFFFF);
    busWrite(32'h88, 32'hFFFFFFFF);
    busWrite(32'h80, 32'h00030001, 4'b0101);
    busRead(32'h80); busRead(32'h84); busRead(32'h30); busRead(32'h88);

    // Count write and EN-clearing CTRL write colliding with ticks
    busWrite(32'h80, 32'd0);
    busWrite(32'h28, 32'hFFFFFFFF);
    busWrite(32'h20, 32'h3);
    busWrite(32'h24, 32'h100);
    busRead(32'h24);
    busWrite(32'h20, 32'h2);
    busRead(32'h24); busRead(32'h20);

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        if ($urandom_range(0, 3) == 0)
          applyStimulus(0, $urandom_range(0, 1) == 1, 0, 1, $urandom(), 4'hF, $urandom());
        else
          idle(1);
      end else begin
        if ($urandom_range(0, 15) < 13) begin
          ch = ($urandom_range(0, 5) == 0) ? int'($urandom_range(3, 7)) : int'($urandom_range(0, 2));
          word = ch * 4 + int'($urandom_range(0, 3));
        end else begin
          case ($urandom_range(0, 3))
            0: word = 32;
            1: word = 33;
            2: word = 34;
            default: word = 63;
          endcase
        end
        adr = ($urandom() & 32'hFFFFFF03) | (32'(word) << 2);
        we = $urandom_range(0, 1) == 1;
        sel = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
        if (word == 32) dat = ($urandom() & 32'hFFFF0000) | 32'($urandom_range(0, 3));
        else if (word < 32 && word % 4 == 1) dat = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 6));
        else if (word < 32 && word % 4 == 2) dat = ($urandom_range(0, 2) != 0) ? 32'($urandom_range(0, 8)) : $urandom();
        else dat = $urandom();
        applyStimulus(0, 1, 1, we, adr, sel, dat);
      end
    end

    // Reset with channel 0 running, MATCH set and a read strobe on the reset edge
    busWrite(32'h80, 32'd0);
    busWrite(32'h08, 32'd1);
    busWrite(32'h04, 32'd0);
    busWrite(32'h00, 32'h7);
    idle(4);
    busRead(32'h04);
    applyStimulus(1, 1, 1, 0, 32'h04, 4'hF, 32'd0);
    @(posedge clk);
    #2;
    checkOutput("dat_o_after_rst", wb_dat_o, 32'd0);
    applyStimulus(0, 0, 0, 0, 32'd0, 4'h0, 32'd0);
    for (int i = 0; i < 4; i++) busRead(32'(i * 4));
    busRead(32'h80); busRead(32'h84);
    idle(3);

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
